// File: rtl/dm_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package dm_arb_pkg;

    localparam int DM_AW = 13;
    localparam int DM_DW = 32;

    typedef enum logic {NORMAL, FORCE} arb_state_t;

    typedef logic [DM_AW-1:0] dm_addr_t;

endpackage

// File: rtl/dm_arb_starve_timer.sv
// Counts consecutive cycles an external request goes ungranted and asks for a
// forced grant once the limit is reached.
module dm_arb_starve_timer
    import dm_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ext_req_i,
    input  logic ext_gnt_i,
    input  logic in_force_i,
    output logic force_req_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          starving;

    assign starving = ext_req_i & ~ext_gnt_i;

    always_comb begin
        wait_cnt_d = '0;
        if (!in_force_i && starving) begin
            wait_cnt_d = (wait_cnt_q == CW'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end

    assign force_req_o = ~in_force_i & starving & (wait_cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the two data-memory ports between the CPU's two memory slots and an
// external requester. Optional perf counters are enabled by DM_ARB_PERF_EN.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW       = DM_AW,
    parameter int DW       = DM_DW,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_re0_i,
    input  logic          cpu_re1_i,
    input  logic          cpu_we0_i,
    input  logic          cpu_we1_i,
    input  logic [AW-1:0] cpu_addr0_i,
    input  logic [AW-1:0] cpu_addr1_i,
    input  logic [DW-1:0] cpu_wdat0_i,
    input  logic [DW-1:0] cpu_wdat1_i,
    output logic          cpu_stall_o,
    input  logic          ext_req_i,
    input  logic          ext_we_i,
    input  logic [AW-1:0] ext_addr_i,
    input  logic [DW-1:0] ext_wdat_i,
    output logic          ext_gnt_o,
    output logic          ext_rvalid_o,
    output logic [DW-1:0] ext_rdat_o,
    output logic [AW-1:0] dm_addr0_o,
    output logic [AW-1:0] dm_addr1_o,
    output logic          dm_re0_o,
    output logic          dm_re1_o,
    output logic          dm_we0_o,
    output logic          dm_we1_o,
    output logic [DW-1:0] dm_wdat0_o,
    output logic [DW-1:0] dm_wdat1_o,
    input  logic [DW-1:0] dm_rdat0_i,
    input  logic [DW-1:0] dm_rdat1_i
`ifdef DM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_stall_cnt_o,
    output logic [31:0]   perf_ext_cnt_o
`endif
);

    arb_state_t state_q, state_d;
    logic       slot0_act, slot1_act, conflict, in_force;
    logic       ext_port, force_req;
    logic       rd_pend_q, rd_port_q;

    assign slot0_act = cpu_re0_i | cpu_we0_i;
    assign slot1_act = cpu_re1_i | cpu_we1_i;
    assign in_force  = (state_q == FORCE);

    // A shared address only blocks the requester when at least one side writes.
    assign conflict =
        (slot0_act & (ext_addr_i == cpu_addr0_i) & (ext_we_i | cpu_we0_i)) |
        (slot1_act & (ext_addr_i == cpu_addr1_i) & (ext_we_i | cpu_we1_i));

    always_comb begin
        ext_gnt_o = 1'b0;
        ext_port  = 1'b0;
        if (!rst) begin
            if (in_force) begin
                ext_gnt_o = ext_req_i;
            end else begin
                ext_port  = ~slot1_act;
                ext_gnt_o = ext_req_i & ~(slot0_act & slot1_act) & ~conflict;
            end
        end
    end

    dm_arb_starve_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .ext_req_i   (ext_req_i),
        .ext_gnt_i   (ext_gnt_o),
        .in_force_i  (in_force),
        .force_req_o (force_req)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= NORMAL;
        else     state_q <= state_d;
    end

    // FORCE never repeats back to back; it always returns to NORMAL.
    always_comb begin
        state_d = NORMAL;
        if (!in_force && force_req) state_d = FORCE;
    end

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        cpu_stall_o = in_force;
        dm_addr0_o  = cpu_addr0_i;
        dm_re0_o    = cpu_re0_i & ~in_force & ~rst;
        dm_we0_o    = cpu_we0_i & ~in_force & ~rst;
        dm_wdat0_o  = cpu_wdat0_i;
        dm_addr1_o  = cpu_addr1_i;
        dm_re1_o    = cpu_re1_i & ~in_force & ~rst;
        dm_we1_o    = cpu_we1_i & ~in_force & ~rst;
        dm_wdat1_o  = cpu_wdat1_i;
        if (ext_gnt_o && !ext_port) begin
            dm_addr0_o = ext_addr_i;
            dm_re0_o   = ~ext_we_i;
            dm_we0_o   = ext_we_i;
            dm_wdat0_o = ext_wdat_i;
        end
        if (ext_gnt_o && ext_port) begin
            dm_addr1_o = ext_addr_i;
            dm_re1_o   = ~ext_we_i;
            dm_we1_o   = ext_we_i;
            dm_wdat1_o = ext_wdat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
        end else begin
            rd_pend_q <= ext_gnt_o & ~ext_we_i;
            rd_port_q <= ext_port;
        end
    end

    // Gating with rst drops a read that was granted just before reset.
    assign ext_rvalid_o = rd_pend_q & ~rst;
    assign ext_rdat_o   = ext_rvalid_o ? (rd_port_q ? dm_rdat1_i : dm_rdat0_i) : '0;

`ifdef DM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_o <= '0;
            perf_ext_cnt_o   <= '0;
        end else begin
            if (in_force && perf_stall_cnt_o != '1) perf_stall_cnt_o <= perf_stall_cnt_o + 1'b1;
            if (ext_gnt_o && perf_ext_cnt_o != '1) perf_ext_cnt_o <= perf_ext_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small dual-port memory model.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_re0, cpu_re1, cpu_we0, cpu_we1;
    logic [12:0] cpu_addr0, cpu_addr1;
    logic [31:0] cpu_wdat0, cpu_wdat1;
    logic        cpu_stall;
    logic        ext_req, ext_we;
    logic [12:0] ext_addr;
    logic [31:0] ext_wdat;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdat;
    logic [12:0] dm_addr0, dm_addr1;
    logic        dm_re0, dm_re1, dm_we0, dm_we1;
    logic [31:0] dm_wdat0, dm_wdat1;
    logic [31:0] dm_rdat0, dm_rdat1;
`ifdef DM_ARB_PERF_EN
    logic [31:0] perf_stall_cnt, perf_ext_cnt;
`endif

    logic [31:0] mem [0:8191];
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dm_we0) mem[dm_addr0] <= dm_wdat0;
        if (dm_we1) mem[dm_addr1] <= dm_wdat1;
        if (dm_re0) dm_rdat0 <= mem[dm_addr0];
        if (dm_re1) dm_rdat1 <= mem[dm_addr1];
    end

    dm_port_arbiter #(.AW(13), .DW(32), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_re0_i(cpu_re0), .cpu_re1_i(cpu_re1), .cpu_we0_i(cpu_we0), .cpu_we1_i(cpu_we1),
        .cpu_addr0_i(cpu_addr0), .cpu_addr1_i(cpu_addr1),
        .cpu_wdat0_i(cpu_wdat0), .cpu_wdat1_i(cpu_wdat1),
        .cpu_stall_o(cpu_stall),
        .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr), .ext_wdat_i(ext_wdat),
        .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid), .ext_rdat_o(ext_rdat),
        .dm_addr0_o(dm_addr0), .dm_addr1_o(dm_addr1),
        .dm_re0_o(dm_re0), .dm_re1_o(dm_re1), .dm_we0_o(dm_we0), .dm_we1_o(dm_we1),
        .dm_wdat0_o(dm_wdat0), .dm_wdat1_o(dm_wdat1),
        .dm_rdat0_i(dm_rdat0), .dm_rdat1_i(dm_rdat1)
`ifdef DM_ARB_PERF_EN
        , .perf_stall_cnt_o(perf_stall_cnt), .perf_ext_cnt_o(perf_ext_cnt)
`endif
    );

    task automatic idle_inputs();
        cpu_re0 = 0; cpu_re1 = 0; cpu_we0 = 0; cpu_we1 = 0;
        cpu_addr0 = '0; cpu_addr1 = '0; cpu_wdat0 = '0; cpu_wdat1 = '0;
        ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdat = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; idle_inputs();
        ext_req = 1; cpu_re0 = 1; cpu_we1 = 1;
        #1;
        n_chk++; if (ext_gnt !== 1'b0) $display("FAIL reset_gnt: got %0b want 0", ext_gnt); else n_pass++;
        n_chk++; if (dm_re0 !== 1'b0) $display("FAIL reset_dm_re0: got %0b want 0", dm_re0); else n_pass++;
        n_chk++; if (dm_we1 !== 1'b0) $display("FAIL reset_dm_we1: got %0b want 0", dm_we1); else n_pass++;
        @(negedge clk);
        n_chk++; if (cpu_stall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", cpu_stall); else n_pass++;
        n_chk++; if (ext_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %0b want 0", ext_rvalid); else n_pass++;
        n_chk++; if (ext_rdat !== 32'h0) $display("FAIL reset_rdat: got %h want 0", ext_rdat); else n_pass++;
        rst = 0; idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_ext_write();
        @(negedge clk);
        idle_inputs();
        ext_req = 1; ext_we = 1; ext_addr = 13'h0100; ext_wdat = 32'hDEADBEEF;
        #1;
        n_chk++; if (ext_gnt !== 1'b1) $display("FAIL wr_gnt: got %0b want 1", ext_gnt); else n_pass++;
        n_chk++; if ({dm_we1, dm_we0, dm_re1} !== 3'b100) $display("FAIL wr_port: got we1/we0/re1=%b want 100", {dm_we1, dm_we0, dm_re1}); else n_pass++;
        n_chk++; if (dm_addr1 !== 13'h0100 || dm_wdat1 !== 32'hDEADBEEF) $display("FAIL wr_bus: got %h/%h want 0100/deadbeef", dm_addr1, dm_wdat1); else n_pass++;
        @(negedge clk);
        idle_inputs();
        #1;
        n_chk++; if (mem[13'h0100] !== 32'hDEADBEEF) $display("FAIL wr_mem: got %h want deadbeef", mem[13'h0100]); else n_pass++;
        n_chk++; if (ext_rvalid !== 1'b0) $display("FAIL wr_no_rvalid: got %0b want 0", ext_rvalid); else n_pass++;
    endtask

    task automatic test_ext_read();
        // Slot0 busy, slot1 idle: requester lands on port1.
        @(negedge clk);
        idle_inputs();
        cpu_re0 = 1; cpu_addr0 = 13'h0010;
        ext_req = 1; ext_addr = 13'h0020;
        #1;
        n_chk++; if (ext_gnt !== 1'b1) $display("FAIL rd1_gnt: got %0b want 1", ext_gnt); else n_pass++;
        n_chk++; if (dm_re1 !== 1'b1 || dm_addr1 !== 13'h0020) $display("FAIL rd1_port1: got re=%0b addr=%h want 1/0020", dm_re1, dm_addr1); else n_pass++;
        n_chk++; if (dm_re0 !== 1'b1 || dm_addr0 !== 13'h0010) $display("FAIL rd1_slot0: got re=%0b addr=%h want 1/0010", dm_re0, dm_addr0); else n_pass++;
        @(negedge clk);
        idle_inputs();
        #1;
        n_chk++; if (ext_rvalid !== 1'b1 || ext_rdat !== 32'h12345678) $display("FAIL rd1_data: got v=%0b d=%h want 1/12345678", ext_rvalid, ext_rdat); else n_pass++;
        @(negedge clk);
        // Slot1 busy, slot0 idle: requester falls back to port0.
        cpu_re1 = 1; cpu_addr1 = 13'h0050;
        ext_req = 1; ext_addr = 13'h0030;
        #1;
        n_chk++; if (ext_gnt !== 1'b1 || dm_re0 !== 1'b1 || dm_addr0 !== 13'h0030) $display("FAIL rd0_port0: got g=%0b re0=%0b a0=%h want 1/1/0030", ext_gnt, dm_re0, dm_addr0); else n_pass++;
        n_chk++; if (dm_re1 !== 1'b1 || dm_addr1 !== 13'h0050) $display("FAIL rd0_slot1: got re=%0b addr=%h want 1/0050", dm_re1, dm_addr1); else n_pass++;
        @(negedge clk);
        idle_inputs();
        #1;
        n_chk++; if (ext_rvalid !== 1'b1 || ext_rdat !== 32'hCAFEF00D) $display("FAIL rd0_data: got v=%0b d=%h want 1/cafef00d", ext_rvalid, ext_rdat); else n_pass++;
    endtask

    task automatic test_starve();
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            cpu_re0 = 1; cpu_addr0 = 13'h0200;
            cpu_re1 = 1; cpu_addr1 = 13'h0201;
            ext_we = 0; ext_addr = 13'h0300;
            ext_req = (cyc <= 9);
            #1;
            n_chk++; if (cpu_stall !== (cyc == 9)) $display("FAIL starve_stall_c%0d: got %0b want %0b", cyc, cpu_stall, cyc == 9); else n_pass++;
            n_chk++; if (ext_gnt !== (cyc == 9)) $display("FAIL starve_gnt_c%0d: got %0b want %0b", cyc, ext_gnt, cyc == 9); else n_pass++;
            if (cyc == 9) begin
                n_chk++; if (dm_re0 !== 1'b1 || dm_addr0 !== 13'h0300 || dm_re1 !== 1'b0) $display("FAIL starve_force_ports: got re0=%0b a0=%h re1=%0b want 1/0300/0", dm_re0, dm_addr0, dm_re1); else n_pass++;
            end
            if (cyc == 10) begin
                n_chk++; if (ext_rvalid !== 1'b1 || ext_rdat !== 32'h0BADF00D) $display("FAIL starve_data: got v=%0b d=%h want 1/0badf00d", ext_rvalid, ext_rdat); else n_pass++;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_conflict();
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            idle_inputs();
            cpu_we1 = (cyc <= 2); cpu_addr1 = 13'h0040; cpu_wdat1 = 32'h00000040;
            ext_req = 1; ext_addr = 13'h0040;
            #1;
            n_chk++; if (ext_gnt !== (cyc == 3)) $display("FAIL conflict_gnt_c%0d: got %0b want %0b", cyc, ext_gnt, cyc == 3); else n_pass++;
        end
        n_chk++; if (dm_re1 !== 1'b1 || dm_addr1 !== 13'h0040) $display("FAIL conflict_port1: got re=%0b addr=%h want 1/0040", dm_re1, dm_addr1); else n_pass++;
        // Read against read at the same address is not a conflict.
        @(negedge clk);
        idle_inputs();
        cpu_re1 = 1; cpu_addr1 = 13'h0040;
        ext_req = 1; ext_addr = 13'h0040;
        #1;
        n_chk++; if (ext_gnt !== 1'b1 || dm_re0 !== 1'b1) $display("FAIL rr_nocon: got g=%0b re0=%0b want 1/1", ext_gnt, dm_re0); else n_pass++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_drop();
        @(negedge clk);
        idle_inputs();
        ext_req = 1; ext_addr = 13'h0020;
        #1;
        n_chk++; if (ext_gnt !== 1'b1) $display("FAIL rstdrop_gnt: got %0b want 1", ext_gnt); else n_pass++;
        @(negedge clk);
        idle_inputs();
        rst = 1;
        #1;
        n_chk++; if (ext_rvalid !== 1'b0 || ext_rdat !== 32'h0) $display("FAIL rstdrop_rvalid: got v=%0b d=%h want 0/0", ext_rvalid, ext_rdat); else n_pass++;
        @(negedge clk);
        rst = 0;
        #1;
        n_chk++; if (ext_rvalid !== 1'b0 || cpu_stall !== 1'b0) $display("FAIL rstdrop_after: got v=%0b stall=%0b want 0/0", ext_rvalid, cpu_stall); else n_pass++;
        @(negedge clk);
        cpu_re0 = 1; cpu_re1 = 1; ext_req = 1; ext_addr = 13'h0500;
        #1;
        n_chk++; if (ext_gnt !== 1'b0 || dm_re0 !== 1'b1) $display("FAIL rstdrop_normal: got g=%0b re0=%0b want 0/1", ext_gnt, dm_re0); else n_pass++;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

`ifdef DM_ARB_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        rst = 1; idle_inputs();
        @(negedge clk);
        rst = 0;
        test_starve();
        test_ext_write();
        #1;
        n_chk++; if (perf_stall_cnt !== 32'd1) $display("FAIL perf_stall: got %0d want 1", perf_stall_cnt); else n_pass++;
        n_chk++; if (perf_ext_cnt !== 32'd2) $display("FAIL perf_ext: got %0d want 2", perf_ext_cnt); else n_pass++;
    endtask
`endif

    initial begin
        mem[13'h0020] = 32'h12345678;
        mem[13'h0030] = 32'hCAFEF00D;
        mem[13'h0300] = 32'h0BADF00D;
        dm_rdat0 = '0; dm_rdat1 = '0;
        rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        test_reset();
        test_ext_write();
        test_ext_read();
        test_starve();
        test_conflict();
        test_reset_drop();
`ifdef DM_ARB_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
